// File: rtl/oram_arb_pkg.sv
// Shared command encodings, FSM state type and command helpers for the ORAM backend arbiter.
package oram_arb_pkg;

  localparam int CMDW = 2;

  localparam logic [CMDW-1:0] BECMD_Update  = 2'd0;
  localparam logic [CMDW-1:0] BECMD_Append  = 2'd1;
  localparam logic [CMDW-1:0] BECMD_Read    = 2'd2;
  localparam logic [CMDW-1:0] BECMD_ReadRmv = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } arb_state_t;

  function automatic logic is_read(input logic [CMDW-1:0] cmd);
    return (cmd == BECMD_Read) || (cmd == BECMD_ReadRmv);
  endfunction

endpackage

// File: rtl/oram_arb_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to rr_ptr.
module oram_arb_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic       pick,
  output logic       any
);

  always_comb begin
    any = |valid;
    case (valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = rr_ptr;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/oram_backend_arbiter.sv
// Two-requester round-robin arbiter holding a grant for a whole ORAM backend transaction.
// Optional per-requester completed-transaction counters: define ORAM_ARB_STATS_EN.
module oram_backend_arbiter
  import oram_arb_pkg::*;
#(
  parameter int ORAMU    = 32,
  parameter int ORAMB    = 512,
  parameter int FEDWidth = 512,
  parameter int NumReq   = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NumReq*CMDW-1:0]     ReqCommand,
  input  logic [NumReq*ORAMU-1:0]    ReqPAddr,
  input  logic [NumReq-1:0]          ReqCommandValid,
  output logic [NumReq-1:0]          ReqCommandReady,
  input  logic [NumReq*FEDWidth-1:0] ReqDataIn,
  input  logic [NumReq-1:0]          ReqDataInValid,
  output logic [NumReq-1:0]          ReqDataInReady,
  output logic [FEDWidth-1:0]        ReqDataOut,
  output logic [NumReq-1:0]          ReqDataOutValid,
  input  logic [NumReq-1:0]          ReqDataOutReady,
  output logic [CMDW-1:0]            ORAMCommand,
  output logic [ORAMU-1:0]           ORAMPAddr,
  output logic                       ORAMCommandValid,
  input  logic                       ORAMCommandReady,
  output logic [FEDWidth-1:0]        ORAMDataIn,
  output logic                       ORAMDataInValid,
  input  logic                       ORAMDataInReady,
  input  logic [FEDWidth-1:0]        ORAMDataOut,
  input  logic                       ORAMDataOutValid,
  output logic                       ORAMDataOutReady,
  output logic [NumReq-1:0]          Grant,
  output logic                       Busy
`ifdef ORAM_ARB_STATS_EN
  ,
  output logic [31:0]                AccessCount0,
  output logic [31:0]                AccessCount1
`endif
);

  localparam int BEATS = ORAMB / FEDWidth;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  arb_state_t     state;
  logic           rr_ptr;
  logic [BCW-1:0] beat_cnt;

  logic pick, any_req;

  oram_arb_rr_pick u_rr_pick (
    .valid  (ReqCommandValid),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .any    (any_req)
  );

  // Index of the current owner; with Grant == 0 every qualifier below is gated off.
  logic g;
  assign g = Grant[1];

  logic [CMDW-1:0]     g_cmd;
  logic [ORAMU-1:0]    g_paddr;
  logic                g_cmd_valid;
  logic [FEDWidth-1:0] g_din;
  logic                g_din_valid;
  logic                g_dout_ready;

  assign g_cmd        = g ? ReqCommand[CMDW +: CMDW]       : ReqCommand[0 +: CMDW];
  assign g_paddr      = g ? ReqPAddr[ORAMU +: ORAMU]       : ReqPAddr[0 +: ORAMU];
  assign g_cmd_valid  = g ? ReqCommandValid[1]             : ReqCommandValid[0];
  assign g_din        = g ? ReqDataIn[FEDWidth +: FEDWidth] : ReqDataIn[0 +: FEDWidth];
  assign g_din_valid  = g ? ReqDataInValid[1]              : ReqDataInValid[0];
  assign g_dout_ready = g ? ReqDataOutReady[1]             : ReqDataOutReady[0];

  logic in_cmd, in_wdata, in_rdata;
  assign in_cmd   = (state == ST_CMD);
  assign in_wdata = (state == ST_WDATA);
  assign in_rdata = (state == ST_RDATA);

  assign ORAMCommand      = g_cmd;
  assign ORAMPAddr        = g_paddr;
  assign ORAMCommandValid = in_cmd & g_cmd_valid;
  assign ReqCommandReady  = (in_cmd && ORAMCommandReady) ? Grant : '0;

  assign ORAMDataIn       = g_din;
  assign ORAMDataInValid  = in_wdata & g_din_valid;
  assign ReqDataInReady   = (in_wdata && ORAMDataInReady) ? Grant : '0;

  // Return data is broadcast; only the owner's valid is raised, and the backend is
  // back-pressured outside RDATA so nothing is dropped or misrouted.
  assign ReqDataOut       = ORAMDataOut;
  assign ReqDataOutValid  = (in_rdata && ORAMDataOutValid) ? Grant : '0;
  assign ORAMDataOutReady = in_rdata & g_dout_ready;

  logic cmd_hs, beat_hs, last_hs;
  assign cmd_hs  = ORAMCommandValid & ORAMCommandReady;
  assign beat_hs = (ORAMDataInValid & ORAMDataInReady) | (ORAMDataOutValid & ORAMDataOutReady);
  assign last_hs = beat_hs && (beat_cnt == LAST_BEAT);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      Grant    <= '0;
      Busy     <= 1'b0;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            Grant <= pick ? 2'b10 : 2'b01;
            Busy  <= 1'b1;
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_hs) begin
            beat_cnt <= '0;
            state    <= is_read(g_cmd) ? ST_RDATA : ST_WDATA;
          end
        end
        ST_WDATA, ST_RDATA: begin
          if (last_hs) begin
            state    <= ST_IDLE;
            Grant    <= '0;
            Busy     <= 1'b0;
            rr_ptr   <= ~g;
            beat_cnt <= '0;
          end else if (beat_hs) begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ORAM_ARB_STATS_EN
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      AccessCount0 <= '0;
      AccessCount1 <= '0;
    end else if (last_hs) begin
      if (g) AccessCount1 <= AccessCount1 + 32'd1;
      else   AccessCount0 <= AccessCount0 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oram_backend_arbiter.sv
// Directed scoreboard bench: a 4-beat instance (FEDWidth=128) and a 1-beat instance (FEDWidth=64).
module tb_oram_backend_arbiter;
  import oram_arb_pkg::*;

  localparam int U  = 32;
  localparam int W  = 128;
  localparam int WB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // 4-beat instance
  logic [3:0]     a_cmd;   logic [2*U-1:0] a_paddr;
  logic [1:0]     a_cmdv,  a_cmdr;
  logic [2*W-1:0] a_din;   logic [1:0] a_dinv, a_dinr;
  logic [W-1:0]   a_dout;  logic [1:0] a_doutv, a_doutr;
  logic [1:0]     a_ocmd;  logic [U-1:0] a_opaddr;
  logic           a_ocmdv, a_ocmdr;
  logic [W-1:0]   a_odin;  logic a_odinv, a_odinr;
  logic [W-1:0]   a_odout; logic a_odoutv, a_odoutr;
  logic [1:0]     a_grant; logic a_busy;
  // 1-beat instance
  logic [3:0]      b_cmd;   logic [2*U-1:0] b_paddr;
  logic [1:0]      b_cmdv,  b_cmdr;
  logic [2*WB-1:0] b_din;   logic [1:0] b_dinv, b_dinr;
  logic [WB-1:0]   b_dout;  logic [1:0] b_doutv, b_doutr;
  logic [1:0]      b_ocmd;  logic [U-1:0] b_opaddr;
  logic            b_ocmdv, b_ocmdr;
  logic [WB-1:0]   b_odin;  logic b_odinv, b_odinr;
  logic [WB-1:0]   b_odout; logic b_odoutv, b_odoutr;
  logic [1:0]      b_grant; logic b_busy;
`ifdef ORAM_ARB_STATS_EN
  logic [31:0] a_cnt0, a_cnt1, b_cnt0, b_cnt1;
`endif

  oram_backend_arbiter #(.ORAMU(U), .ORAMB(512), .FEDWidth(W), .NumReq(2)) dut (
    .Clock(clk), .Reset(rst_n),
    .ReqCommand(a_cmd), .ReqPAddr(a_paddr), .ReqCommandValid(a_cmdv), .ReqCommandReady(a_cmdr),
    .ReqDataIn(a_din), .ReqDataInValid(a_dinv), .ReqDataInReady(a_dinr),
    .ReqDataOut(a_dout), .ReqDataOutValid(a_doutv), .ReqDataOutReady(a_doutr),
    .ORAMCommand(a_ocmd), .ORAMPAddr(a_opaddr), .ORAMCommandValid(a_ocmdv), .ORAMCommandReady(a_ocmdr),
    .ORAMDataIn(a_odin), .ORAMDataInValid(a_odinv), .ORAMDataInReady(a_odinr),
    .ORAMDataOut(a_odout), .ORAMDataOutValid(a_odoutv), .ORAMDataOutReady(a_odoutr),
    .Grant(a_grant), .Busy(a_busy)
`ifdef ORAM_ARB_STATS_EN
    , .AccessCount0(a_cnt0), .AccessCount1(a_cnt1)
`endif
  );

  oram_backend_arbiter #(.ORAMU(U), .ORAMB(WB), .FEDWidth(WB), .NumReq(2)) dut_b (
    .Clock(clk), .Reset(rst_n),
    .ReqCommand(b_cmd), .ReqPAddr(b_paddr), .ReqCommandValid(b_cmdv), .ReqCommandReady(b_cmdr),
    .ReqDataIn(b_din), .ReqDataInValid(b_dinv), .ReqDataInReady(b_dinr),
    .ReqDataOut(b_dout), .ReqDataOutValid(b_doutv), .ReqDataOutReady(b_doutr),
    .ORAMCommand(b_ocmd), .ORAMPAddr(b_opaddr), .ORAMCommandValid(b_ocmdv), .ORAMCommandReady(b_ocmdr),
    .ORAMDataIn(b_odin), .ORAMDataInValid(b_odinv), .ORAMDataInReady(b_odinr),
    .ORAMDataOut(b_odout), .ORAMDataOutValid(b_odoutv), .ORAMDataOutReady(b_odoutr),
    .Grant(b_grant), .Busy(b_busy)
`ifdef ORAM_ARB_STATS_EN
    , .AccessCount0(b_cnt0), .AccessCount1(b_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations are pushed as stimulus is driven, popped on DUT handshakes.
  logic [U+1:0] cmd_q[$];
  logic [W-1:0] wr_q[$];
  logic [W+1:0] rd_q[$];

  always @(negedge clk) begin
    if (a_ocmdv && a_ocmdr) begin
      if (cmd_q.size() == 0) chk("cmd_extra", 256'(cmd_q.size()), 256'd1);
      else chk("cmd_fwd", {a_ocmd, a_opaddr}, cmd_q.pop_front());
    end
    if (a_odinv && a_odinr) begin
      if (wr_q.size() == 0) chk("wr_extra", 256'(wr_q.size()), 256'd1);
      else chk("wr_beat", a_odin, wr_q.pop_front());
    end
    if (|(a_doutv & a_doutr)) begin
      if (rd_q.size() == 0) chk("rd_extra", 256'(rd_q.size()), 256'd1);
      else chk("rd_beat", {a_doutv, a_dout}, rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_cmd_accept(input int i);
    int n = 0;
    while (!(a_cmdr[i] && a_cmdv[i]) && n < 50) begin @(negedge clk); n++; end
    chk("cmd_accept", a_cmdr[i], 1'b1);
    tick();
    a_cmdv[i] = 1'b0;
  endtask

  task automatic a_wr_beat(input int i, input logic [W-1:0] d);
    int n = 0;
    a_din[i*W +: W] = d;
    a_dinv[i] = 1'b1;
    wr_q.push_back(d);
    while (!a_dinr[i] && n < 50) begin @(negedge clk); n++; end
    chk("wr_ready", a_dinr[i], 1'b1);
    tick();
    a_dinv[i] = 1'b0;
  endtask

  task automatic a_rd_beat(input logic [1:0] owner, input logic [W-1:0] d);
    int n = 0;
    a_odout = d;
    a_odoutv = 1'b1;
    rd_q.push_back({owner, d});
    while (!a_odoutr && n < 50) begin @(negedge clk); n++; end
    chk("rd_ready", a_odoutr, 1'b1);
    tick();
    a_odoutv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_cmd = '0; a_paddr = '0; a_cmdv = '0; a_din = '0; a_dinv = '0; a_doutr = 2'b11;
    a_ocmdr = 1'b1; a_odinr = 1'b1; a_odout = '0; a_odoutv = 1'b0;
    b_cmd = '0; b_paddr = '0; b_cmdv = '0; b_din = '0; b_dinv = '0; b_doutr = 2'b11;
    b_ocmdr = 1'b1; b_odinr = 1'b1; b_odout = '0; b_odoutv = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_ocmdv", a_ocmdv, 1'b0);
    chk("rst_odoutr", a_odoutr, 1'b0);
    chk("rst_dinr", a_dinr, 2'b00);
    chk("rst_b_grant", b_grant, 2'b00);
    tick(); rst_n = 1'b1;
    tick();

    // Single-beat read from req0 on the 1-beat instance
    b_cmd = {BECMD_Update, BECMD_Read}; b_paddr = {32'h99, 32'h10}; b_cmdv = 2'b01;
    @(negedge clk);
    chk("b_cmdv_latency", b_ocmdv, 1'b0);
    @(negedge clk);
    chk("b_cmdv", b_ocmdv, 1'b1);
    chk("b_cmd", b_ocmd, BECMD_Read);
    chk("b_paddr", b_opaddr, 32'h10);
    chk("b_grant", b_grant, 2'b01);
    chk("b_cmdr", b_cmdr, 2'b01);
    tick(); b_cmdv = 2'b00;
    b_odout = 64'hDEAD_BEEF_0123_4567; b_odoutv = 1'b1;
    @(negedge clk);
    chk("b_doutv", b_doutv, 2'b01);
    chk("b_dout", b_dout, 64'hDEAD_BEEF_0123_4567);
    chk("b_odoutr", b_odoutr, 1'b1);
    tick(); b_odoutv = 1'b0;
    @(negedge clk);
    chk("b_idle_grant", b_grant, 2'b00);
    chk("b_idle_busy", b_busy, 1'b0);

    // req1 4-beat Update with a 2-cycle bubble; req0 waves junk write data meanwhile
    tick();
    a_cmd[3:2] = BECMD_Update; a_paddr[63:32] = 32'h200; a_cmdv[1] = 1'b1;
    cmd_q.push_back({BECMD_Update, 32'h200});
    a_cmd_accept(1);
    a_din[W-1:0] = {4{32'hBAD0_BAD0}}; a_dinv[0] = 1'b1;
    a_wr_beat(1, {4{32'h1111_0000}});
    a_wr_beat(1, {4{32'h2222_0001}});
    @(negedge clk);
    chk("nongrant_dinr", a_dinr[0], 1'b0);
    chk("bubble_odinv", a_odinv, 1'b0);
    tick(); tick();
    a_wr_beat(1, {4{32'h3333_0002}});
    a_wr_beat(1, {4{32'h4444_0003}});
    a_dinv[0] = 1'b0;
    @(negedge clk);
    chk("wr_idle_busy", a_busy, 1'b0);
    chk("wr_idle_grant", a_grant, 2'b00);
    chk("wr_q_empty", 256'(wr_q.size()), 256'd0);

    // req0 Update stalled by ORAMCommandReady=0 for 10 cycles
    tick();
    a_ocmdr = 1'b0;
    a_cmd[1:0] = BECMD_Update; a_paddr[31:0] = 32'h40; a_cmdv[0] = 1'b1;
    cmd_q.push_back({BECMD_Update, 32'h40});
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("stall_cmdr", a_cmdr, 2'b00);
      chk("stall_ocmdv", a_ocmdv, 1'b1);
      chk("stall_cmd", a_ocmd, BECMD_Update);
      chk("stall_paddr", a_opaddr, 32'h40);
    end
    tick(); a_ocmdr = 1'b1;
    a_cmd_accept(0);
    for (int k = 0; k < 4; k++) a_wr_beat(0, {4{32'h5500_0000 + 32'(k)}});
    @(negedge clk);
    chk("stall_idle_busy", a_busy, 1'b0);

    // Reset during beat 2 of a 4-beat read
    tick();
    a_cmd[1:0] = BECMD_Read; a_paddr[31:0] = 32'h80; a_cmdv[0] = 1'b1;
    cmd_q.push_back({BECMD_Read, 32'h80});
    a_cmd_accept(0);
    a_rd_beat(2'b01, {4{32'hAAAA_0000}});
    a_odout = {4{32'hAAAA_0001}}; a_odoutv = 1'b1;
    rd_q.push_back({2'b01, a_odout});
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_grant", a_grant, 2'b00);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_doutv", a_doutv, 2'b00);
    chk("mid_rst_odoutr", a_odoutr, 1'b0);
    chk("mid_rst_ocmdv", a_ocmdv, 1'b0);
    chk("mid_rst_cmdr", a_cmdr, 2'b00);
    chk("mid_rst_dinr", a_dinr, 2'b00);
    chk("mid_rst_odinv", a_odinv, 1'b0);
`ifdef ORAM_ARB_STATS_EN
    chk("mid_rst_cnt0", a_cnt0, 32'd0);
    chk("mid_rst_cnt1", a_cnt1, 32'd0);
`endif
    tick(); a_odoutv = 1'b0; rst_n = 1'b1;
    tick();

    // Contention right after reset: req0, then req1, then req0 again
    for (int r = 0; r < 2; r++) begin
      a_cmd = {BECMD_Read, BECMD_ReadRmv};
      a_paddr = {32'h1100 + 32'(r), 32'h1000 + 32'(r)};
      a_cmdv = 2'b11;
      cmd_q.push_back({BECMD_ReadRmv, 32'h1000 + 32'(r)});
      cmd_q.push_back({BECMD_Read, 32'h1100 + 32'(r)});
      @(negedge clk);
      @(negedge clk);
      chk("rr_first_req0", a_grant, 2'b01);
      a_cmd_accept(0);
      for (int k = 0; k < 4; k++) a_rd_beat(2'b01, {4{32'hC000_0000 + 32'(16 * r + k)}});
      @(negedge clk);
      chk("rr_gap_grant", a_grant, 2'b00);
      @(negedge clk);
      chk("rr_second_req1", a_grant, 2'b10);
      a_cmd_accept(1);
      for (int k = 0; k < 4; k++) a_rd_beat(2'b10, {4{32'hD000_0000 + 32'(16 * r + k)}});
    end
    @(negedge clk);
    chk("end_busy", a_busy, 1'b0);
    chk("rd_q_empty", 256'(rd_q.size()), 256'd0);
    chk("cmd_q_empty", 256'(cmd_q.size()), 256'd0);
`ifdef ORAM_ARB_STATS_EN
    chk("cnt0", a_cnt0, 32'd2);
    chk("cnt1", a_cnt1, 32'd2);
    chk("b_cnt0", b_cnt0, 32'd0);
    chk("b_cnt1", b_cnt1, 32'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
